// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op code constants (OP_W bits wide)
//   - default multi-cycle latencies
//   - operation class and FSM state enums
//   - mul64 helper: 32x32 -> 64 product, signed or unsigned
package mdu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] MD_NONE = 4'd0;
  localparam logic [OP_W-1:0] MULT    = 4'd1;
  localparam logic [OP_W-1:0] MULTU   = 4'd2;
  localparam logic [OP_W-1:0] DIV     = 4'd3;
  localparam logic [OP_W-1:0] DIVU    = 4'd4;
  localparam logic [OP_W-1:0] MTHI    = 4'd5;
  localparam logic [OP_W-1:0] MTLO    = 4'd6;
  localparam logic [OP_W-1:0] MADD    = 4'd7;
  localparam logic [OP_W-1:0] MADDU   = 4'd8;
  localparam logic [OP_W-1:0] MSUB    = 4'd9;
  localparam logic [OP_W-1:0] MSUBU   = 4'd10;

  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  // How the top level must treat a decoded op.
  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_MOVE,
    CLS_MUL,
    CLS_DIV
  } mdu_class_e;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } mdu_state_e;

  // Low 64 bits of the product of the (optionally sign-extended) operands;
  // this equals the exact signed or unsigned 64-bit product.
  function automatic logic [63:0] mul64(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic        sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {{32{sgn & a[31]}}, a};
    eb = {{32{sgn & b[31]}}, b};
    return ea * eb;
  endfunction

endpackage

// File: rtl/mdu_core.sv
// mdu_core: combinational datapath of the multiply/divide unit.
// Produces the 64-bit {HI,LO} value an op would leave behind.
//   op       in   operation code
//   a, b     in   operands rs / rt
//   hi, lo   in   current HI/LO (accumulate base, and the untouched half
//                 for mthi/mtlo)
//   result   out  {HI,LO} candidate
//   div_zero out  divide op with b == 0 (result must not be committed)
//   cls      out  operation class
// Macro MDU_MADD_EN enables the madd/maddu/msub/msubu ops.
module mdu_core
  import mdu_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  input  logic [31:0]     hi,
  input  logic [31:0]     lo,
  output logic [63:0]     result,
  output logic            div_zero,
  output mdu_class_e      cls
);

  logic        b_zero;
  logic        b_neg1;
  logic [31:0] bs;
  logic [31:0] bu;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  always_comb begin
    b_zero = (b == '0);
    b_neg1 = (b == '1);
    // Divisors 0 and -1 are replaced by 1 so the dividers never see a
    // zero divisor or the MIN/-1 overflow; those cases are patched below.
    bs = (b_zero || b_neg1) ? 32'd1 : b;
    bu = b_zero ? 32'd1 : b;

    q_s = $signed(a) / $signed(bs);
    r_s = $signed(a) % $signed(bs);
    if (b_neg1) begin
      // x / -1 = -x, wrapping so that 0x80000000 / -1 = 0x80000000.
      q_s = '0 - a;
      r_s = '0;
    end

    q_u = a / bu;
    r_u = a % bu;

    prod_s = mul64(a, b, 1'b1);
    prod_u = mul64(a, b, 1'b0);

    result   = '0;
    div_zero = 1'b0;
    cls      = CLS_NONE;

    case (op)
      MULT: begin
        result = prod_s;
        cls    = CLS_MUL;
      end
      MULTU: begin
        result = prod_u;
        cls    = CLS_MUL;
      end
      DIV: begin
        result   = {r_s, q_s};
        div_zero = b_zero;
        cls      = CLS_DIV;
      end
      DIVU: begin
        result   = {r_u, q_u};
        div_zero = b_zero;
        cls      = CLS_DIV;
      end
      MTHI: begin
        result = {a, lo};
        cls    = CLS_MOVE;
      end
      MTLO: begin
        result = {hi, a};
        cls    = CLS_MOVE;
      end
`ifdef MDU_MADD_EN
      MADD: begin
        result = {hi, lo} + prod_s;
        cls    = CLS_MUL;
      end
      MADDU: begin
        result = {hi, lo} + prod_u;
        cls    = CLS_MUL;
      end
      MSUB: begin
        result = {hi, lo} - prod_s;
        cls    = CLS_MUL;
      end
      MSUBU: begin
        result = {hi, lo} - prod_u;
        cls    = CLS_MUL;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with architectural HI/LO.
//   clk    in   clock, all state on posedge
//   reset  in   asynchronous active-high reset
//   start  in   issue strobe
//   op     in   operation code (mdu_pkg)
//   A, B   in   operands rs / rt
//   flush  in   cancels the issue sampled this edge
//   busy   out  operation in flight (counter != 0)
//   done   out  one-cycle pulse after a multi-cycle op commits
//   HI, LO out  architectural HI/LO
// Parameters MULT_CYCLES / DIV_CYCLES (both >= 1) set the busy latency.
// Macro MDU_MADD_EN enables madd/maddu/msub/msubu.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     A,
  input  logic [31:0]     B,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [31:0]     HI,
  output logic [31:0]     LO
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  mdu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] shadow_q, shadow_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_d, lo_d;
  logic        done_d;
  logic        accept;

  logic [63:0] core_result;
  logic        core_dz;
  mdu_class_e  core_cls;

  mdu_core u_core (
    .op       (op),
    .a        (A),
    .b        (B),
    .hi       (HI),
    .lo       (LO),
    .result   (core_result),
    .div_zero (core_dz),
    .cls      (core_cls)
  );

  assign busy   = (cnt_q != '0);
  assign accept = start && !flush && !busy;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    dz_d     = dz_q;
    hi_d     = HI;
    lo_d     = LO;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (core_cls)
            CLS_MOVE: {hi_d, lo_d} = core_result;
            CLS_MUL: begin
              cnt_d    = CW'(MULT_CYCLES);
              shadow_d = core_result;
              dz_d     = 1'b0;
              state_d  = S_RUN;
            end
            CLS_DIV: begin
              cnt_d    = CW'(DIV_CYCLES);
              shadow_d = core_result;
              dz_d     = core_dz;
              state_d  = S_RUN;
            end
            default: begin
            end
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (!dz_q) {hi_d, lo_d} = shadow_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      dz_q     <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      dz_q     <= dz_d;
      HI       <= hi_d;
      LO       <= lo_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .HI    (HI),
    .LO    (LO)
  );

  // Drive one issue cycle; operands are scrambled afterwards so a design
  // that fails to capture them at the accepting edge gives wrong results.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit fl, input bit now);
    if (!now) @(negedge clk);
    op = o; A = a; B = b; flush = fl; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    A = $urandom; B = $urandom;
  endtask

  // Returns at the first negedge where busy is low.
  task automatic wait_done(output int bc, output int dc, output bit to);
    bc = 0; dc = 0; to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) dc++;
      if (busy === 1'b1) bc++;
      else begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = MD_NONE; A = '0; B = '0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", HI); end
    checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", LO); end
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult();
    int bc, dc; bit to; exp_t e;
    sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
    issue(MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    wait_done(bc, dc, to);
    checks++; if (to) begin errors++; $display("FAIL mult_timeout busy still high got 1 exp 0"); end
    checks++; if (bc != MC) begin errors++; $display("FAIL mult_busy_cycles got %0d exp %0d", bc, MC); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mult_done_at_commit got %b exp 1", done); end
    e = sb.pop_front(); m_hi = e.hi; m_lo = e.lo;
    checks++; if (HI !== e.hi) begin errors++; $display("FAIL mult_hi got %h exp %h", HI, e.hi); end
    checks++; if (LO !== e.lo) begin errors++; $display("FAIL mult_lo got %h exp %h", LO, e.lo); end
    @(negedge clk);
    if (done === 1'b1) dc++;
    checks++; if (dc != 1) begin errors++; $display("FAIL mult_done_pulses got %0d exp 1", dc); end
  endtask

  task automatic test_div();
    int bc, dc; bit to; exp_t e;
    logic [3:0]  ops [3] = '{DIV, DIVU, DIV};
    logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] bs  [3] = '{32'd2, 32'd2, 32'hFFFF_FFFF};
    exp_t        es  [3] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h1, 32'h7FFF_FFFC},
                             {32'h0, 32'h8000_0000}};
    for (int i = 0; i < 3; i++) begin
      sb.push_back(es[i]);
      issue(ops[i], as[i], bs[i], 1'b0, 1'b0);
      wait_done(bc, dc, to);
      checks++; if (bc != DC || to) begin errors++; $display("FAIL div%0d_busy_cycles got %0d exp %0d", i, bc, DC); end
      e = sb.pop_front(); m_hi = e.hi; m_lo = e.lo;
      checks++; if (HI !== e.hi) begin errors++; $display("FAIL div%0d_hi got %h exp %h", i, HI, e.hi); end
      checks++; if (LO !== e.lo) begin errors++; $display("FAIL div%0d_lo got %h exp %h", i, LO, e.lo); end
      checks++; if (dc != 1) begin errors++; $display("FAIL div%0d_done got %0d exp 1", i, dc); end
    end
  endtask

  task automatic test_divzero();
    int bc, dc; bit to; exp_t e;
    issue(MTHI, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    m_hi = 32'h1234_5678;
    checks++; if (HI !== m_hi) begin errors++; $display("FAIL mthi_hi got %h exp %h", HI, m_hi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mthi_done got %b exp 0", done); end
    issue(MTLO, 32'hCAFE_0001, 32'h0, 1'b0, 1'b1);
    m_lo = 32'hCAFE_0001;
    checks++; if (LO !== m_lo || HI !== m_hi) begin errors++; $display("FAIL mtlo_hilo got %h_%h exp %h_%h", HI, LO, m_hi, m_lo); end
    sb.push_back({m_hi, m_lo});
    issue(DIVU, 32'd55, 32'd0, 1'b0, 1'b0);
    wait_done(bc, dc, to);
    checks++; if (bc != DC || to) begin errors++; $display("FAIL divzero_busy_cycles got %0d exp %0d", bc, DC); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL divzero_done got %b exp 1", done); end
    e = sb.pop_front();
    checks++; if (HI !== e.hi) begin errors++; $display("FAIL divzero_hi got %h exp %h", HI, e.hi); end
    checks++; if (LO !== e.lo) begin errors++; $display("FAIL divzero_lo got %h exp %h", LO, e.lo); end
  endtask

  task automatic test_flush();
    int bc, dc; bit to; exp_t e;
    issue(MULT, 32'd2, 32'd3, 1'b1, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_issue_busy got %b exp 0", busy); end
    @(negedge clk);
    checks++; if (HI !== m_hi || LO !== m_lo) begin errors++; $display("FAIL flush_issue_hilo got %h_%h exp %h_%h", HI, LO, m_hi, m_lo); end
    sb.push_back({32'h0, 32'd6});
    issue(MULT, 32'd2, 32'd3, 1'b0, 1'b0);
    flush = 1'b1;
    wait_done(bc, dc, to);
    flush = 1'b0;
    e = sb.pop_front(); m_hi = e.hi; m_lo = e.lo;
    checks++; if (bc != MC || to) begin errors++; $display("FAIL flush_mid_busy_cycles got %0d exp %0d", bc, MC); end
    checks++; if (HI !== e.hi || LO !== e.lo) begin errors++; $display("FAIL flush_mid_hilo got %h_%h exp %h_%h", HI, LO, e.hi, e.lo); end
  endtask

  task automatic test_back_to_back();
    int bc, dc; bit to; exp_t e;
    sb.push_back({32'h0, 32'd63});
    issue(MULTU, 32'd7, 32'd9, 1'b0, 1'b0);
    wait_done(bc, dc, to);
    e = sb.pop_front(); m_hi = e.hi; m_lo = e.lo;
    checks++; if (HI !== e.hi || LO !== e.lo) begin errors++; $display("FAIL b2b_first_hilo got %h_%h exp %h_%h", HI, LO, e.hi, e.lo); end
    sb.push_back({32'd2, 32'd14});
    issue(DIVU, 32'd100, 32'd7, 1'b0, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy got %b exp 1", busy); end
    wait_done(bc, dc, to);
    e = sb.pop_front(); m_hi = e.hi; m_lo = e.lo;
    checks++; if (bc != DC || to) begin errors++; $display("FAIL b2b_busy_cycles got %0d exp %0d", bc, DC); end
    checks++; if (HI !== e.hi || LO !== e.lo) begin errors++; $display("FAIL b2b_second_hilo got %h_%h exp %h_%h", HI, LO, e.hi, e.lo); end
  endtask

  task automatic test_random();
    int bc, dc; bit to; exp_t e;
    logic [3:0] o; logic [31:0] a, b; longint p; longint unsigned pu;
    int sa, sbv; int unsigned ua, ub;
    for (int i = 0; i < 8; i++) begin
      o = 4'($urandom_range(1, 4)); a = $urandom; b = $urandom;
      if (i == 1) b = 32'h0000_0003;
      if (b == 32'h0) b = 32'd1;
      if (o == DIV && b == 32'hFFFF_FFFF) b = 32'd5;
      case (o)
        MULT:  begin p = longint'(signed'(a)) * longint'(signed'(b)); e = p; end
        MULTU: begin pu = longint'(a) * longint'(b); e = pu; end
        DIV:   begin sa = a; sbv = b; e = {32'(sa % sbv), 32'(sa / sbv)}; end
        default: begin ua = a; ub = b; e = {ua % ub, ua / ub}; end
      endcase
      sb.push_back(e);
      issue(o, a, b, 1'b0, 1'b0);
      wait_done(bc, dc, to);
      e = sb.pop_front(); m_hi = e.hi; m_lo = e.lo;
      checks++; if (bc != ((o <= MULTU) ? MC : DC) || to) begin errors++; $display("FAIL rand%0d_busy op %0d got %0d", i, o, bc); end
      checks++; if (HI !== e.hi || LO !== e.lo) begin errors++; $display("FAIL rand%0d_hilo op %0d a %h b %h got %h_%h exp %h_%h", i, o, a, b, HI, LO, e.hi, e.lo); end
    end
  endtask

  task automatic test_madd();
`ifdef MDU_MADD_EN
    int bc, dc; bit to; exp_t e;
    issue(MTHI, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(MTLO, 32'd10, 32'h0, 1'b0, 1'b1);
    sb.push_back({32'h0, 32'd30});
    issue(MADD, 32'd4, 32'd5, 1'b0, 1'b0);
    wait_done(bc, dc, to);
    e = sb.pop_front();
    checks++; if (bc != MC || to) begin errors++; $display("FAIL madd_busy got %0d exp %0d", bc, MC); end
    checks++; if (HI !== e.hi || LO !== e.lo) begin errors++; $display("FAIL madd_hilo got %h_%h exp %h_%h", HI, LO, e.hi, e.lo); end
    sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFF});
    issue(MSUBU, 32'd1, 32'd31, 1'b0, 1'b0);
    wait_done(bc, dc, to);
    e = sb.pop_front(); m_hi = e.hi; m_lo = e.lo;
    checks++; if (HI !== e.hi || LO !== e.lo) begin errors++; $display("FAIL msubu_hilo got %h_%h exp %h_%h", HI, LO, e.hi, e.lo); end
`else
    for (int i = 7; i <= 10; i++) begin
      issue(4'(i), 32'd4, 32'd5, 1'b0, 1'b0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL op%0d_busy got %b exp 0", i, busy); end
      @(negedge clk);
      checks++; if (HI !== m_hi || LO !== m_lo || done !== 1'b0) begin errors++; $display("FAIL op%0d_nochange got %h_%h done %b exp %h_%h done 0", i, HI, LO, done, m_hi, m_lo); end
    end
`endif
  endtask

  task automatic test_async_reset();
    int dc;
    issue(DIV, 32'd1000, 32'd7, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b exp 0", busy); end
    checks++; if (HI !== 32'h0 || LO !== 32'h0) begin errors++; $display("FAIL areset_hilo got %h_%h exp 0_0", HI, LO); end
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    dc = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) dc++;
    end
    checks++; if (dc != 0) begin errors++; $display("FAIL areset_late_done got %0d exp 0", dc); end
    checks++; if (HI !== 32'h0 || LO !== 32'h0) begin errors++; $display("FAIL areset_late_hilo got %h_%h exp 0_0", HI, LO); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_divzero();
    test_flush();
    test_back_to_back();
    test_random();
    test_madd();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
